// File: rtl/seq_detect_param_if.sv
// Serial pattern detector bus: data input, config load, match outputs.
// master drives i_valid/i/cfg_*/cnt_clr; slave drives y/match_cnt/cfg_err.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    logic               i_valid;
    logic               i;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output i_valid, i, cfg_load, cfg_pattern,
        output cfg_len, cfg_overlap, cnt_clr,
        input  y, match_cnt, cfg_err
    );

    modport slave (
        input  i_valid, i, cfg_load, cfg_pattern,
        input  cfg_len, cfg_overlap, cnt_clr,
        output y, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with Moore match flag.
// Ports: clk, rst (async, active-high), bus (seq_detect_param_if.slave).
// Optional macro SEQDET_MATCH_CNT_EN builds the saturating match counter;
// without it match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);
    typedef enum logic {
        IDLE,
        MATCH
    } state_t;

    localparam logic [3:0]         LMAX    = 4'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(5'b10110);

    logic [MAX_LEN-1:0] pat_q;
    logic [3:0]         len_q;
    logic               ovl_q;
    logic               err_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [3:0]         fill_q;
    state_t             state_q;
    state_t             state_d;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [3:0]         fill_inc;
    logic               accept;
    logic               hit;

    // cfg_load wins over a same-cycle data bit
    assign accept = bus.i_valid && !bus.cfg_load;

    always_comb begin
        mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            mask[k] = (k < int'(len_q));
        end
        hist_nxt = {hist_q[MAX_LEN-2:0], bus.i};
        fill_inc = (fill_q == LMAX) ? fill_q : fill_q + 4'd1;
        // err_q also covers len 0, where the empty mask would match
        hit = !err_q && (fill_inc >= len_q) &&
              (((hist_nxt ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= RST_PAT;
            len_q  <= 4'd5;
            ovl_q  <= 1'b1;
            err_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.cfg_load) begin
            pat_q  <= bus.cfg_pattern;
            len_q  <= bus.cfg_len;
            ovl_q  <= bus.cfg_overlap;
            err_q  <= (bus.cfg_len == 4'd0) || (bus.cfg_len > LMAX);
            hist_q <= '0;
            fill_q <= '0;
        end else if (accept) begin
            hist_q <= hist_nxt;
            // non-overlap: next match needs len fresh bits
            fill_q <= (hit && !ovl_q) ? 4'd0 : fill_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.cfg_load) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = hit ? MATCH : IDLE;
        end
    end

    assign bus.y       = (state_q == MATCH);
    assign bus.cfg_err = err_q;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && hit) begin
            if (bus.cnt_clr) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..15.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  qualifies i; a bit is accepted only on a rising edge with i_valid=1.
REQ-006 i  input  1  serial data bit.
REQ-007 cfg_load  input  1  pulse; latches cfg_pattern, cfg_len and cfg_overlap into the active config registers.
REQ-008 cfg_pattern  input  MAX_LEN  target pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
REQ-009 cfg_len  input  4  pattern length in bits.
REQ-010 cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 y  output  1  Moore match flag, registered.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 cfg_err  output  1  active config is illegal; detector is disabled.

Function
REQ-015 Internal state: active config registers, MAX_LEN-bit history shift register (new bit enters at LSB), fill counter 0..MAX_LEN, and match state register.
REQ-016 Accepted bit: hist <= {hist[MAX_LEN-2:0], i}; fill <= min(fill+1, MAX_LEN).
REQ-017 Match condition: on an accepted bit, updated fill >= len and updated hist[len-1:0] == pattern[len-1:0]; the match state is entered on that edge.
REQ-018 y is a Moore output of the match state: it is 1 from the edge that accepted the completing bit until the next accepted bit, and is never a combinational function of i.
REQ-019 An accepted bit that does not complete a match clears the match state, so y returns to 0 on that edge.
REQ-020 Overlap mode: fill is retained after a match, so a pattern suffix may start the next match.
REQ-021 Non-overlap mode: on a match edge fill is set to 0, so the next match requires len fresh bits.
REQ-022 Consecutive matches hold y at 1 continuously (e.g. len=2, pattern 11, overlap, stream 1111 gives y=1 after bits 2, 3 and 4).
REQ-023 cfg_load takes priority over i_valid in the same cycle: the bit is discarded; hist, fill and y are cleared; the new config is active from the next edge.
REQ-024 Illegal config is cfg_len < 1 or cfg_len > MAX_LEN; on loading it, cfg_err=1 and no match state is ever entered until a legal cfg_load.
REQ-025 match_cnt increments by 1 on each edge that enters or re-enters the match state, and saturates at 2^CNT_W-1.
REQ-026 cnt_clr together with a match edge gives match_cnt=1; cnt_clr alone gives match_cnt=0.
REQ-027 Latency: the completing bit accepted on edge N gives y=1 and the updated match_cnt visible after edge N.

Reset
REQ-028 rst=1 asynchronously forces y=0, match_cnt=0, cfg_err=0, hist=0 and fill=0.
REQ-029 Reset values of the active config: pattern = 10110 in the LSBs, len=5, overlap=1.
REQ-030 Reset asserted mid-stream discards partial progress; detection restarts with the first bit accepted after release.

Configuration
REQ-031 Macro SEQDET_MATCH_CNT_EN: when defined, the match_cnt logic of REQ-025/026 is built.
REQ-032 Without SEQDET_MATCH_CNT_EN: the match_cnt port is still present and tied to 0, cnt_clr is ignored, and y behaviour is unchanged.

Verification
REQ-033 After reset, with no cfg_load, stream 10110 -> y=1 after bit 5 only; match_cnt=1.
REQ-034 Load pattern 1011, len 4, overlap=1; stream 1011011 -> y=1 after bits 4 and 7; match_cnt=2.
REQ-035 Same pattern with overlap=0; stream 1011011 -> y=1 after bit 4 only; match_cnt=1.
REQ-036 Load len=0 -> cfg_err=1; 20 bits of 1 -> y stays 0; then load len=1, pattern 1 -> cfg_err=0 and y=1 after the next accepted 1.
REQ-037 cfg_load and i_valid in the same cycle mid-pattern -> bit discarded and y=0; the full pattern is then required again.
REQ-038 CNT_W=2, len=1, pattern 1; 6 ones -> match_cnt saturates at 3; cnt_clr on a match edge -> match_cnt=1; rst mid-pattern -> y=0 and match_cnt=0 immediately.
